// File: rtl/memwb_skid.sv
// MEM/WB pipeline stage built as a two-entry skid buffer with a valid/ready
// handshake, write-back value selection and forwarding-hit detection.
module memwb_skid #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter int WB_W         = 2,
  parameter int REGWRITE_BIT = 1,
  parameter int MEMTOREG_BIT = 0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [WB_W-1:0]   wb_i,
  input  logic [DATA_W-1:0] read_data_i,
  input  logic [DATA_W-1:0] alu_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [WB_W-1:0]   wb_o,
  output logic [DATA_W-1:0] read_data_o,
  output logic [DATA_W-1:0] alu_o,
  output logic [REG_W-1:0]  rd_o,
  output logic [DATA_W-1:0] wb_data_o,
  input  logic [REG_W-1:0]  rs_i,
  input  logic [REG_W-1:0]  rt_i,
  output logic              fwd_rs_o,
  output logic              fwd_rt_o,
  output logic [1:0]        occupancy_o
);

  localparam int ENT_W = WB_W + 2 * DATA_W + REG_W;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ENT_W-1:0]   head_q, head_d;
  logic [ENT_W-1:0]   skid_q, skid_d;
  logic               in_ready_q, in_ready_d;
  logic [ENT_W-1:0]   in_ent_s;
  logic [WB_W-1:0]    head_wb_s;
  logic               accept_s;
  logic               pop_s;

  assign in_ent_s = {wb_i, read_data_i, alu_i, rd_i};
  assign {head_wb_s, read_data_o, alu_o, rd_o} = head_q;

  assign out_valid_o = (state_q != EMPTY);
  assign in_ready_o  = in_ready_q;
  assign occupancy_o = state_q;
  assign accept_s    = in_valid_i & in_ready_q;
  assign pop_s       = out_valid_o & out_ready_i;

  // A bubble must never write the register file, so wb is masked when idle.
  assign wb_o      = out_valid_o ? head_wb_s : {WB_W{1'b0}};
  assign wb_data_o = wb_o[MEMTOREG_BIT] ? read_data_o : alu_o;
  assign fwd_rs_o  = out_valid_o & wb_o[REGWRITE_BIT] & (rd_o != {REG_W{1'b0}}) & (rd_o == rs_i);
  assign fwd_rt_o  = out_valid_o & wb_o[REGWRITE_BIT] & (rd_o != {REG_W{1'b0}}) & (rd_o == rt_i);

  // Next-state and datapath selection; flush overrides every handshake.
  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    skid_d  = skid_q;
    if (flush_i) begin
      state_d = EMPTY;
      head_d  = {ENT_W{1'b0}};
      skid_d  = {ENT_W{1'b0}};
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept_s) begin
            head_d  = in_ent_s;
            state_d = ONE;
          end else begin
            state_d = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && pop_s) begin
            head_d  = in_ent_s;
          end else if (accept_s) begin
            skid_d  = in_ent_s;
            state_d = TWO;
          end else if (pop_s) begin
            state_d = EMPTY;
          end else begin
            state_d = ONE;
          end
        end
        TWO: begin
          if (pop_s) begin
            head_d  = skid_q;
            state_d = ONE;
          end else begin
            state_d = TWO;
          end
        end
        default: begin
          state_d = EMPTY;
          head_d  = {ENT_W{1'b0}};
          skid_d  = {ENT_W{1'b0}};
        end
      endcase
    end
    in_ready_d = (state_d != TWO);
  end

  // State, entry and ready registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= EMPTY;
      head_q     <= {ENT_W{1'b0}};
      skid_q     <= {ENT_W{1'b0}};
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

endmodule

// File: tb/tb_memwb_skid.sv
// Scoreboard bench for memwb_skid: accepted entries are queued and every
// popped head entry is compared against the queue front.
module tb_memwb_skid;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [4:0]  rd;
  } ent_t;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [1:0]  wb_i;
  logic [31:0] read_data_i;
  logic [31:0] alu_i;
  logic [4:0]  rd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [1:0]  wb_o;
  logic [31:0] read_data_o;
  logic [31:0] alu_o;
  logic [4:0]  rd_o;
  logic [31:0] wb_data_o;
  logic [4:0]  rs_i;
  logic [4:0]  rt_i;
  logic        fwd_rs_o;
  logic        fwd_rt_o;
  logic [1:0]  occupancy_o;

  int   n_checks = 0;
  int   n_fail   = 0;
  ent_t sb[$];

  memwb_skid dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .wb_i(wb_i), .read_data_i(read_data_i), .alu_i(alu_i), .rd_i(rd_i),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .wb_o(wb_o), .read_data_o(read_data_o), .alu_o(alu_o), .rd_o(rd_o),
    .wb_data_o(wb_data_o), .rs_i(rs_i), .rt_i(rt_i),
    .fwd_rs_o(fwd_rs_o), .fwd_rt_o(fwd_rt_o), .occupancy_o(occupancy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic ent_t mk(input logic [1:0] wb, input logic [31:0] rdata,
                              input logic [31:0] alu, input logic [4:0] rd);
    ent_t e;
    e.wb = wb; e.rdata = rdata; e.alu = alu; e.rd = rd;
    return e;
  endfunction

  // One clock cycle: drive at posedge+1, sample handshakes at negedge.
  task automatic step(input logic v, input ent_t e, input logic ordy, input logic fl,
                      output logic acc, output logic popped, output ent_t got);
    in_valid_i = v; wb_i = e.wb; read_data_i = e.rdata; alu_i = e.alu; rd_i = e.rd;
    out_ready_i = ordy; flush_i = fl;
    @(negedge clk_i);
    acc    = v && in_ready_o && !fl;
    popped = out_valid_o && ordy && !fl;
    got    = {wb_o, read_data_o, alu_o, rd_o};
    @(posedge clk_i); #1;
    if (fl) sb.delete();
    else if (acc) sb.push_back(e);
  endtask

  task automatic test_reset();
    rst_i = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    wb_i = 2'b00; read_data_i = 32'h0; alu_i = 32'h0; rd_i = 5'd0; rs_i = 5'd0; rt_i = 5'd0;
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ctrl occ=%0d valid=%b ready=%b required occ=0 valid=0 ready=1",
               occupancy_o, out_valid_o, in_ready_o);
    end
    n_checks++;
    if ({wb_o, read_data_o, alu_o, rd_o} !== 71'd0) begin
      n_fail++;
      $display("FAIL reset_data got=%h required=0", {wb_o, read_data_o, alu_o, rd_o});
    end
    rst_i = 1'b1;
    @(posedge clk_i); #1;
  endtask

  task automatic test_pass_through();
    ent_t st[4];
    ent_t got, exp;
    logic acc, popped;
    st[0] = mk(2'b10, 32'h0, 32'h10, 5'd3);
    st[1] = mk(2'b10, 32'h0, 32'h20, 5'd4);
    st[2] = '0;
    st[3] = '0;
    for (int i = 0; i < 4; i++) begin
      step(i < 2, st[i], 1'b1, 1'b0, acc, popped, got);
      if (popped) begin
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL pass_data cyc=%0d got=%h required=%h", i, got, exp);
        end
      end
      n_checks++;
      if (occupancy_o !== 2'(sb.size()) || (i < 2 && occupancy_o !== 2'd1)) begin
        n_fail++;
        $display("FAIL pass_occ cyc=%0d got=%0d required=%0d", i, occupancy_o, sb.size());
      end
    end
  endtask

  task automatic test_backpressure();
    ent_t got, exp, c;
    logic acc, popped, c_done;
    int n_out;
    step(1'b1, mk(2'b10, 32'hA1, 32'hA2, 5'd1), 1'b0, 1'b0, acc, popped, got);
    step(1'b1, mk(2'b11, 32'hB1, 32'hB2, 5'd2), 1'b0, 1'b0, acc, popped, got);
    n_checks++;
    if (occupancy_o !== 2'd2 || in_ready_o !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_full occ=%0d ready=%b required occ=2 ready=0", occupancy_o, in_ready_o);
    end
    c = mk(2'b01, 32'hC1, 32'hC2, 5'd3);
    step(1'b1, c, 1'b0, 1'b0, acc, popped, got);
    n_checks++;
    if (acc !== 1'b0 || occupancy_o !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_hold acc=%b occ=%0d required acc=0 occ=2", acc, occupancy_o);
    end
    c_done = 1'b0;
    n_out = 0;
    for (int i = 0; i < 12 && !(c_done && sb.size() == 0); i++) begin
      step(!c_done, c, 1'b1, 1'b0, acc, popped, got);
      if (acc) c_done = 1'b1;
      if (popped) begin
        n_out++;
        exp = sb.pop_front();
        n_checks++;
        if (got !== exp) begin
          n_fail++;
          $display("FAIL bp_order n=%0d got=%h required=%h", n_out, got, exp);
        end
      end
    end
    n_checks++;
    if (n_out != 3 || sb.size() != 0) begin
      n_fail++;
      $display("FAIL bp_count outputs=%0d left=%0d required outputs=3 left=0", n_out, sb.size());
    end
  endtask

  task automatic test_flush();
    ent_t got;
    logic acc, popped;
    step(1'b1, mk(2'b10, 32'h1, 32'h2, 5'd5), 1'b0, 1'b0, acc, popped, got);
    step(1'b1, mk(2'b10, 32'h3, 32'h4, 5'd6), 1'b0, 1'b0, acc, popped, got);
    step(1'b1, mk(2'b11, 32'hCC, 32'hCD, 5'd9), 1'b0, 1'b1, acc, popped, got);
    n_checks++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || wb_o !== 2'b00 || in_ready_o !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_state occ=%0d valid=%b wb=%b ready=%b required 0/0/00/1",
               occupancy_o, out_valid_o, wb_o, in_ready_o);
    end
    n_checks++;
    if ({read_data_o, alu_o, rd_o} !== 69'd0) begin
      n_fail++;
      $display("FAIL flush_clear got=%h required=0", {read_data_o, alu_o, rd_o});
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, '0, 1'b1, 1'b0, acc, popped, got);
      n_checks++;
      if (popped !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_leak cyc=%0d got=%h required no output", i, got);
      end
    end
  endtask

  task automatic test_forwarding();
    ent_t got, exp;
    logic acc, popped;
    step(1'b1, mk(2'b10, 32'h0, 32'h77, 5'd7), 1'b0, 1'b0, acc, popped, got);
    rs_i = 5'd7; rt_i = 5'd0; #1;
    n_checks++;
    if (fwd_rs_o !== 1'b1 || fwd_rt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_hit rs=%b rt=%b required rs=1 rt=0", fwd_rs_o, fwd_rt_o);
    end
    rt_i = 5'd7; rs_i = 5'd6; #1;
    n_checks++;
    if (fwd_rs_o !== 1'b0 || fwd_rt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fwd_rt rs=%b rt=%b required rs=0 rt=1", fwd_rs_o, fwd_rt_o);
    end
    step(1'b0, '0, 1'b1, 1'b0, acc, popped, got);
    if (popped) begin
      exp = sb.pop_front();
      n_checks++;
      if (got !== exp) begin
        n_fail++;
        $display("FAIL fwd_data got=%h required=%h", got, exp);
      end
    end
    n_checks++;
    if (fwd_rt_o !== 1'b0 || wb_o !== 2'b00) begin
      n_fail++;
      $display("FAIL fwd_bubble rt=%b wb=%b required rt=0 wb=00", fwd_rt_o, wb_o);
    end
    step(1'b1, mk(2'b10, 32'h0, 32'h55, 5'd0), 1'b0, 1'b0, acc, popped, got);
    rs_i = 5'd0; rt_i = 5'd0; #1;
    n_checks++;
    if (fwd_rs_o !== 1'b0 || fwd_rt_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_r0 rs=%b rt=%b required rs=0 rt=0", fwd_rs_o, fwd_rt_o);
    end
    step(1'b0, '0, 1'b1, 1'b0, acc, popped, got);
    if (popped) void'(sb.pop_front());
  endtask

  task automatic test_wb_select();
    ent_t got;
    logic acc, popped;
    logic [1:0]  wbs[2];
    logic [31:0] want[2];
    wbs[0] = 2'b11; want[0] = 32'hDEAD;
    wbs[1] = 2'b10; want[1] = 32'hBEEF;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, mk(wbs[i], 32'hDEAD, 32'hBEEF, 5'd8), 1'b0, 1'b0, acc, popped, got);
      n_checks++;
      if (wb_data_o !== want[i]) begin
        n_fail++;
        $display("FAIL wb_sel wb=%b got=%h required=%h", wbs[i], wb_data_o, want[i]);
      end
      step(1'b0, '0, 1'b1, 1'b0, acc, popped, got);
      if (popped) void'(sb.pop_front());
    end
  endtask

  task automatic test_async_reset();
    ent_t got, exp, e;
    logic acc, popped;
    step(1'b1, mk(2'b10, 32'h11, 32'h12, 5'd1), 1'b0, 1'b0, acc, popped, got);
    step(1'b1, mk(2'b11, 32'h21, 32'h22, 5'd2), 1'b0, 1'b0, acc, popped, got);
    in_valid_i = 1'b0;
    #2 rst_i = 1'b0;
    #1;
    n_checks++;
    if (occupancy_o !== 2'd0 || out_valid_o !== 1'b0 || in_ready_o !== 1'b1 ||
        {wb_o, read_data_o, alu_o, rd_o} !== 71'd0) begin
      n_fail++;
      $display("FAIL async_rst occ=%0d valid=%b ready=%b data=%h required 0/0/1/0",
               occupancy_o, out_valid_o, in_ready_o, {wb_o, read_data_o, alu_o, rd_o});
    end
    sb.delete();
    #2 rst_i = 1'b1;
    @(posedge clk_i); #1;
    e = mk(2'b01, 32'h31, 32'h32, 5'd3);
    step(1'b1, e, 1'b0, 1'b0, acc, popped, got);
    n_checks++;
    if (occupancy_o !== 2'd1 || acc !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_first occ=%0d acc=%b required occ=1 acc=1", occupancy_o, acc);
    end
    step(1'b0, '0, 1'b1, 1'b0, acc, popped, got);
    n_checks++;
    if (!popped || sb.size() == 0) begin
      n_fail++;
      $display("FAIL rst_pop popped=%b required 1", popped);
    end else begin
      exp = sb.pop_front();
      if (got !== exp) begin
        n_fail++;
        $display("FAIL rst_data got=%h required=%h", got, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    ent_t got, exp, pend;
    logic acc, popped, have;
    have = 1'b0;
    pend = '0;
    for (int i = 0; i < 300 || (sb.size() != 0 && i < 330); i++) begin
      if (!have && i < 300 && $urandom_range(0, 3) != 0) begin
        pend = mk(2'($urandom), $urandom, $urandom, 5'($urandom));
        have = 1'b1;
      end
      step(have, pend, (i >= 300) || ($urandom_range(0, 2) != 0), 1'b0, acc, popped, got);
      if (acc) have = 1'b0;
      if (popped) begin
        n_checks++;
        if (sb.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra cyc=%0d got=%h required no output", i, got);
        end else begin
          exp = sb.pop_front();
          if (got !== exp) begin
            n_fail++;
            $display("FAIL b2b_data cyc=%0d got=%h required=%h", i, got, exp);
          end
        end
      end
      n_checks++;
      if (occupancy_o !== 2'(sb.size()) || in_ready_o !== (sb.size() < 2)) begin
        n_fail++;
        $display("FAIL b2b_occ cyc=%0d occ=%0d ready=%b required occ=%0d", i, occupancy_o,
                 in_ready_o, sb.size());
      end
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_drain left=%0d required 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_pass_through();
    test_backpressure();
    test_flush();
    test_forwarding();
    test_wb_select();
    test_async_reset();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/memwb_skid.md
MEMWB_SKID -- requirements
Module: memwb_skid

Interface
REQ-001 SHALL have parameter DATA_W, default 32, width of read-data, ALU-result and write-back data paths.
REQ-002 SHALL have parameter REG_W, default 5, width of destination and source register numbers.
REQ-003 SHALL have parameter WB_W, default 2, width of the write-back control field.
REQ-004 SHALL have parameter REGWRITE_BIT, default 1, index of RegWrite within the WB field.
REQ-005 SHALL have parameter MEMTOREG_BIT, default 0, index of MemtoReg within the WB field.
REQ-006 SHALL have port clk_i, input, 1, single clock, all state updates on rising edge.
REQ-007 SHALL have port rst_i, input, 1, asynchronous active-low reset.
REQ-008 SHALL have port flush_i, input, 1, synchronous flush of all held entries.
REQ-009 SHALL have port in_valid_i, input, 1, upstream entry valid.
REQ-010 SHALL have port in_ready_o, output, 1, stage can accept an entry (registered).
REQ-011 SHALL have ports wb_i (WB_W), read_data_i (DATA_W), alu_i (DATA_W), rd_i (REG_W), all inputs, upstream entry fields.
REQ-012 SHALL have port out_valid_o, output, 1, head entry valid.
REQ-013 SHALL have port out_ready_i, input, 1, downstream accepts head entry.
REQ-014 SHALL have ports wb_o, read_data_o, alu_o, rd_o, outputs, head entry fields.
REQ-015 SHALL have port wb_data_o, output, DATA_W, selected write-back value.
REQ-016 SHALL have ports rs_i, rt_i, inputs, REG_W, consumer source registers; fwd_rs_o, fwd_rt_o, outputs, 1, forwarding hits.
REQ-017 SHALL have port occupancy_o, output, 2, number of held entries (0..2).

Function
REQ-018 SHALL hold up to two entries: head register (drives outputs) and skid register.
REQ-019 SHALL implement states EMPTY, ONE, TWO; occupancy_o SHALL equal 0/1/2 respectively.
REQ-020 Accept SHALL occur when in_valid_i and in_ready_o are both 1; pop SHALL occur when out_valid_o and out_ready_i are both 1.
REQ-021 EMPTY: accept -> head loads input, ONE; otherwise stay.
REQ-022 ONE: accept and pop -> head loads input, stay ONE; accept only -> skid loads input, TWO; pop only -> EMPTY; neither -> hold.
REQ-023 TWO: in_ready_o SHALL be 0; pop -> head loads skid, ONE; otherwise hold.
REQ-024 in_ready_o SHALL be registered and equal 1 exactly when next state is not TWO; latency input-to-output SHALL be one cycle.
REQ-025 out_valid_o SHALL be 1 in ONE and TWO, 0 in EMPTY.
REQ-026 wb_o SHALL be forced to 0 whenever out_valid_o is 0 (bubble, no register-file write); other output fields SHALL hold last value.
REQ-027 wb_data_o SHALL equal read_data_o when wb_o[MEMTOREG_BIT] is 1, else alu_o (combinational).
REQ-028 fwd_rs_o SHALL be 1 iff out_valid_o, wb_o[REGWRITE_BIT], rd_o != 0 and rd_o == rs_i; fwd_rt_o likewise with rt_i (combinational).
REQ-029 flush_i SHALL have priority over all handshakes: next state EMPTY, head and skid fields cleared to 0, any same-cycle input dropped, in_ready_o 1 next cycle.
REQ-030 Entry order SHALL be preserved; no entry SHALL be duplicated or lost except by flush.

Reset
REQ-031 rst_i low SHALL immediately force state EMPTY, all data/control registers 0, out_valid_o 0, occupancy_o 0, in_ready_o 1.
REQ-032 Reset asserted mid-operation SHALL discard both entries; first accept after release SHALL behave as from EMPTY.

Verification
REQ-033 Pass-through: out_ready_i=1, entries A (wb=2'b10, alu=0x10, rd=3), B (alu=0x20, rd=4) on consecutive cycles -> outputs A then B one cycle after each, occupancy_o stays 1.
REQ-034 Backpressure: out_ready_i=0, send A, B -> occupancy 2, in_ready_o 0; C held upstream; out_ready_i=1 -> A, B, C emerge in order, nothing lost.
REQ-035 Flush: state TWO with A, B, flush_i=1 with in_valid_i=1 carrying C -> next cycle occupancy 0, out_valid_o 0, wb_o 0, C never output.
REQ-036 Forwarding: head wb=2'b10, rd=7, rs_i=7, rt_i=0 -> fwd_rs_o 1, fwd_rt_o 0; rd=0 with rs_i=0 -> fwd_rs_o 0.
REQ-037 Write-back select: wb=2'b11, read_data=0xDEAD, alu=0xBEEF -> wb_data_o 0xDEAD; wb=2'b10 -> 0xBEEF.
REQ-038 Async reset: assert rst_i low between clock edges in state TWO -> outputs zero and in_ready_o 1 before next edge.
